smi_mem_write_burst_target: RTL

- Responder end of the SMI memory write-burst protocol.
- Accepts SMI write request frames, decodes the 14-byte header, and issues one memory write command.
- Strips the header and realigns the payload onto a 64-bit memory write stream.
- Waits for the memory completion, then returns a single-flit write response frame to the initiator.

---
 rtl/smi_mem_write_burst_target_pkg.sv | 36 +++
 rtl/smi_mem_write_burst_target_realign.sv | 87 ++++++++
 rtl/smi_mem_write_burst_target.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/smi_mem_write_burst_target_pkg.sv
// Shared constants, state encoding and helpers for the SMI memory write-burst responder.
package smi_mem_write_burst_target_pkg;

  localparam logic [7:0] WRITE_REQ_ID              = 8'h01;
  localparam logic [7:0] WRITE_RESP_ID             = 8'hFE;
  localparam logic [7:0] SMI_MEM_WRITE_OPT_DEFAULT = 8'h00;
  localparam logic [7:0] SMI_MEM_WRITE_OPT_DIRECT  = 8'h01;
  localparam int         RESP_ERR_BIT              = 9;
  localparam int         HDR_BYTES                 = 14;
  // Header bytes carried by the second flit; eofc equal to this means zero payload.
  localparam logic [7:0] HDR_HI_BYTES              = 8'(HDR_BYTES - 8);
  localparam logic [7:0] RESP_EOFC                 = 8'd4;

  typedef enum logic [2:0] {
    HdrLo, HdrHi, CmdIssue, Payload, Flush, AwaitDone, Drain, SendResp
  } state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [15:0] len;
    logic [7:0]  opts;
  } memCmd_t;

  // Bytes left in the held register when a flit ending with eofc 7/8 is consumed.
  function automatic logic [1:0] flushBytes(input logic [7:0] eofc);
    return (eofc >= 8'd8) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [63:0] respFlit(input logic err);
    logic [63:0] f;
    f = {56'd0, WRITE_RESP_ID};
    f[RESP_ERR_BIT] = err;
    return f;
  endfunction

endpackage

// File: rtl/smi_mem_write_burst_target_realign.sv
// Payload realignment: shifts the stream by the two header-flit payload bytes,
// remaps eofc, generates the trailing flush flit and counts written bytes.
module smi_mem_write_burst_target_realign
  import smi_mem_write_burst_target_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        payloadActive,
  input  logic        flushActive,
  input  logic        hdrLoad,
  input  logic [15:0] hdrHeld,
  input  logic [7:0]  hdrEofc,
  input  logic        clrCnt,
  input  logic        reqValid,
  input  logic [7:0]  reqEofc,
  input  logic [63:0] reqData,
  output logic        payStop,
  output logic        wrValid,
  output logic [7:0]  wrEofc,
  output logic [63:0] wrData,
  input  logic        wrStop,
  output logic        payLast,
  output logic        payToFlush,
  output logic        flushXfer,
  output logic [15:0] byteCnt
);

  logic [15:0] held;
  logic [1:0]  pending;
  logic [7:0]  nBytes;
  logic        isLast, lastWide, payXfer;
  logic [16:0] sum;

  assign isLast   = reqEofc != 8'd0;
  assign lastWide = reqEofc > 8'd6;

  always_comb begin
    wrValid = 1'b0;
    wrEofc  = 8'd0;
    wrData  = 64'd0;
    nBytes  = 8'd0;
    payStop = 1'b1;
    if (payloadActive) begin
      wrValid = reqValid;
      wrData  = {reqData[47:0], held};
      payStop = wrStop;
      if (isLast && !lastWide) begin
        wrEofc = reqEofc + 8'd2;
        nBytes = reqEofc + 8'd2;
      end else begin
        nBytes = 8'd8;
      end
    end else if (flushActive) begin
      wrValid = 1'b1;
      wrData  = {48'd0, held};
      wrEofc  = {6'd0, pending};
      nBytes  = {6'd0, pending};
    end
  end

  assign payXfer    = payloadActive & reqValid & ~wrStop;
  assign payLast    = payXfer & isLast;
  assign payToFlush = payLast & lastWide;
  assign flushXfer  = flushActive & ~wrStop;

  // Saturating count: any overflow must still mismatch the 16-bit length.
  assign sum = {1'b0, byteCnt} + {9'd0, nBytes};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      held    <= 16'd0;
      pending <= 2'd0;
      byteCnt <= 16'd0;
    end else begin
      if (hdrLoad) begin
        held    <= hdrHeld;
        pending <= flushBytes(hdrEofc);
      end else if (payXfer) begin
        held <= reqData[63:48];
        if (payToFlush) pending <= flushBytes(reqEofc);
      end
      if (clrCnt) byteCnt <= 16'd0;
      else if (payXfer || flushXfer) byteCnt <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

endmodule

// File: rtl/smi_mem_write_burst_target.sv
// SMI memory write-burst responder: header decode, one memory command,
// realigned payload stream, completion wait and single-flit response.
module smi_mem_write_burst_target
  import smi_mem_write_burst_target_pkg::*;
#(
  parameter int MaxBurstLen = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        smiReqValid,
  input  logic [7:0]  smiReqEofc,
  input  logic [63:0] smiReqData,
  output logic        smiReqStop,
  output logic        smiRespValid,
  output logic [7:0]  smiRespEofc,
  output logic [63:0] smiRespData,
  input  logic        smiRespStop,
  output logic        memCmdValid,
  output logic [63:0] memCmdAddr,
  output logic [15:0] memCmdLen,
  output logic [7:0]  memCmdOpts,
  input  logic        memCmdStop,
  output logic        memWriteValid,
  output logic [7:0]  memWriteEofc,
  output logic [63:0] memWriteData,
  input  logic        memWriteStop,
  input  logic        memDoneValid,
  input  logic        memDoneStatusOk,
  output logic        memDoneStop
);

  localparam logic [16:0] MaxLenLim = 17'(MaxBurstLen);

  state_t      state, nextState;
  memCmd_t     cmdReg;
  logic [7:0]  idReg;
  logic        err, hdrLast, armed;
  logic        reqXfer, badHdr, shortHdr, zeroPay;
  logic        payStop, payLast, payToFlush, flushXfer;
  logic [15:0] byteCnt, lenIn;

  assign lenIn    = smiReqData[47:32];
  assign badHdr   = (idReg != WRITE_REQ_ID) || ({1'b0, lenIn} > MaxLenLim);
  assign shortHdr = (smiReqEofc != 8'd0) && (smiReqEofc < HDR_HI_BYTES);
  assign zeroPay  = smiReqEofc == HDR_HI_BYTES;
  assign reqXfer  = smiReqValid & ~smiReqStop;

  smi_mem_write_burst_target_realign uRealign (
    .clk          (clk),
    .rstn         (rstn),
    .payloadActive(state == Payload),
    .flushActive  (state == Flush),
    .hdrLoad      ((state == HdrHi) && reqXfer),
    .hdrHeld      (smiReqData[63:48]),
    .hdrEofc      (smiReqEofc),
    .clrCnt       ((state == SendResp) && !smiRespStop),
    .reqValid     (smiReqValid),
    .reqEofc      (smiReqEofc),
    .reqData      (smiReqData),
    .payStop      (payStop),
    .wrValid      (memWriteValid),
    .wrEofc       (memWriteEofc),
    .wrData       (memWriteData),
    .wrStop       (memWriteStop),
    .payLast      (payLast),
    .payToFlush   (payToFlush),
    .flushXfer    (flushXfer),
    .byteCnt      (byteCnt)
  );

  always_comb begin
    nextState    = state;
    smiReqStop   = 1'b1;
    memCmdValid  = 1'b0;
    memDoneStop  = 1'b1;
    smiRespValid = 1'b0;
    case (state)
      HdrLo: begin
        // Stop stays high for the first cycle out of reset.
        smiReqStop = ~armed;
        if (smiReqValid && armed) nextState = (smiReqEofc != 8'd0) ? SendResp : HdrHi;
      end
      HdrHi: begin
        smiReqStop = 1'b0;
        if (smiReqValid) begin
          if (badHdr)                 nextState = (smiReqEofc == 8'd0) ? Drain : SendResp;
          else if (shortHdr || zeroPay) nextState = SendResp;
          else                        nextState = CmdIssue;
        end
      end
      CmdIssue: begin
        memCmdValid = 1'b1;
        if (!memCmdStop) nextState = hdrLast ? Flush : Payload;
      end
      Payload: begin
        smiReqStop = payStop;
        if (payLast) nextState = payToFlush ? Flush : AwaitDone;
      end
      Flush: if (flushXfer) nextState = AwaitDone;
      AwaitDone: begin
        memDoneStop = 1'b0;
        if (memDoneValid) nextState = SendResp;
      end
      Drain: begin
        smiReqStop = 1'b0;
        if (smiReqValid && smiReqEofc != 8'd0) nextState = SendResp;
      end
      SendResp: begin
        smiRespValid = 1'b1;
        if (!smiRespStop) nextState = HdrLo;
      end
      default: nextState = HdrLo;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= HdrLo;
      cmdReg  <= '0;
      idReg   <= 8'd0;
      err     <= 1'b0;
      hdrLast <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state <= nextState;
      armed <= 1'b1;
      case (state)
        HdrLo: if (reqXfer) begin
          idReg              <= smiReqData[7:0];
          cmdReg.opts        <= smiReqData[15:8];
          cmdReg.addr[31:0]  <= smiReqData[63:32];
          if (smiReqEofc != 8'd0) err <= 1'b1;
        end
        HdrHi: if (reqXfer) begin
          cmdReg.addr[63:32] <= smiReqData[31:0];
          cmdReg.len         <= lenIn;
          hdrLast            <= smiReqEofc != 8'd0;
          if (badHdr || shortHdr || (zeroPay && lenIn != 16'd0)) err <= 1'b1;
        end
        AwaitDone: if (memDoneValid)
          err <= err | ~memDoneStatusOk | (byteCnt != cmdReg.len);
        SendResp: if (!smiRespStop) err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign memCmdAddr  = cmdReg.addr;
  assign memCmdLen   = cmdReg.len;
  assign memCmdOpts  = cmdReg.opts;
  assign smiRespEofc = smiRespValid ? RESP_EOFC : 8'd0;
  assign smiRespData = smiRespValid ? respFlit(err) : 64'd0;

endmodule
